// File: rtl/arb_rr_n.sv
// arb_rr_n -- N-channel package arbiter between the slave ports and the
// formatter. One requesting slave is granted per package. The granted
// slave's data beats are forwarded for the latched package length, and the
// channel is held until the formatter acknowledges the package.
//
// Build option:
//   ARB_PRIO_EN  defined   : lowest priority value wins, round-robin breaks ties
//                undefined : slv_prio_i ignored, pure round-robin from rr_ptr+1
//
// Ports:
//   clk_i, rst_i        clock (rising edge) / asynchronous active-high reset
//   slv_prio_i          per-channel priority, channel c at [c*PRIO_W +: PRIO_W]
//   slv_pkglen_i        per-channel package length select
//   slv_data_i          per-channel data
//   slv_req_i           per-channel package request
//   slv_val_i           per-channel data valid
//   a2s_ack_o           one-cycle grant pulse to the winning slave
//   f2a_id_req_i        formatter ready for a new package
//   f2a_ack_i           formatter consumed the current package
//   a2f_val_o           forwarded data valid
//   a2f_id_o            granted channel index
//   a2f_data_o          forwarded data (holds while a2f_val_o=0)
//   a2f_pkglen_sel_o    latched length select of the granted channel
//
// state | meaning
// IDLE  | waiting for formatter ready and any request
// ARB   | one cycle: pick winner, latch id/pkglen, pulse ack
// XFER  | forwarding granted channel's beats until target reached
// DONE  | waiting for formatter acknowledge

module arb_rr_n #(
   parameter int NUM_CH = 4,
   parameter int DW     = 32,
   parameter int PRIO_W = 2,
   parameter int LEN_W  = 3,
   localparam int ID_W  = $clog2(NUM_CH)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_CH*PRIO_W-1:0]   slv_prio_i,
   input  logic [NUM_CH*LEN_W-1:0]    slv_pkglen_i,
   input  logic [NUM_CH*DW-1:0]       slv_data_i,
   input  logic [NUM_CH-1:0]          slv_req_i,
   input  logic [NUM_CH-1:0]          slv_val_i,
   output logic [NUM_CH-1:0]          a2s_ack_o,
   input  logic                       f2a_id_req_i,
   input  logic                       f2a_ack_i,
   output logic                       a2f_val_o,
   output logic [ID_W-1:0]            a2f_id_o,
   output logic [DW-1:0]              a2f_data_o,
   output logic [LEN_W-1:0]           a2f_pkglen_sel_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARB  = 2'd1,
      S_XFER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [LEN_W-1:0]    pkglen_q, pkglen_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [NUM_CH-1:0]   ack_q, ack_d;
   logic                val_q, val_d;
   logic [DW-1:0]       data_q, data_d;

   logic [NUM_CH-1:0]   elig;
   logic                found;
   logic [ID_W-1:0]     win_id;
   logic [5:0]          tgt;

   // Candidate set: all requesters, or only those at the best priority.
`ifdef ARB_PRIO_EN
   logic [PRIO_W-1:0]   min_prio;

   always_comb begin
      min_prio = '1;
      for (int c = 0; c < NUM_CH; c++) begin
         if (slv_req_i[c] && (slv_prio_i[c*PRIO_W +: PRIO_W] < min_prio))
            min_prio = slv_prio_i[c*PRIO_W +: PRIO_W];
      end
      elig = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         elig[c] = slv_req_i[c] && (slv_prio_i[c*PRIO_W +: PRIO_W] == min_prio);
      end
   end
`else
   logic unused_prio;
   assign unused_prio = ^slv_prio_i;

   always_comb begin
      elig = slv_req_i;
   end
`endif

   // Round-robin scan starting one past the last winner, wrapping at NUM_CH.
   always_comb begin
      int idx;
      idx    = 0;
      found  = 1'b0;
      win_id = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && elig[idx]) begin
            found  = 1'b1;
            win_id = ID_W'(idx);
         end
      end
   end

   always_comb begin
      if (pkglen_q == '0)               tgt = 6'd4;
      else if (pkglen_q == LEN_W'(1))   tgt = 6'd8;
      else if (pkglen_q == LEN_W'(2))   tgt = 6'd16;
      else                              tgt = 6'd32;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      pkglen_d = pkglen_q;
      cnt_d    = cnt_q;
      ack_d    = '0;
      val_d    = 1'b0;
      data_d   = data_q;
      case (state_q)
         S_IDLE: begin
            if (f2a_id_req_i && (|slv_req_i)) state_d = S_ARB;
         end
         S_ARB: begin
            if (found) begin
               id_d          = win_id;
               rr_ptr_d      = win_id;
               pkglen_d      = slv_pkglen_i[win_id*LEN_W +: LEN_W];
               ack_d[win_id] = 1'b1;
               cnt_d         = '0;
               state_d       = S_XFER;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_XFER: begin
            if (slv_val_i[id_q]) begin
               val_d  = 1'b1;
               data_d = slv_data_i[id_q*DW +: DW];
               cnt_d  = cnt_q + 6'd1;
               if ((cnt_q + 6'd1) == tgt) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (f2a_ack_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= ID_W'(NUM_CH-1);
         id_q     <= '0;
         pkglen_q <= '0;
         cnt_q    <= '0;
         ack_q    <= '0;
         val_q    <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         pkglen_q <= pkglen_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         val_q    <= val_d;
         data_q   <= data_d;
      end
   end

   assign a2s_ack_o        = ack_q;
   assign a2f_val_o        = val_q;
   assign a2f_id_o         = id_q;
   assign a2f_data_o       = data_q;
   assign a2f_pkglen_sel_o = pkglen_q;

endmodule

// File: tb/tb_arb_rr_n.sv
module tb_arb_rr_n;

   localparam int NUM_CH = 4;
   localparam int DW     = 32;
   localparam int PRIO_W = 2;
   localparam int LEN_W  = 3;
   localparam int ID_W   = $clog2(NUM_CH);

   logic                      clk_i;
   logic                      rst_i;
   logic [NUM_CH*PRIO_W-1:0]  slv_prio_i;
   logic [NUM_CH*LEN_W-1:0]   slv_pkglen_i;
   logic [NUM_CH*DW-1:0]      slv_data_i;
   logic [NUM_CH-1:0]         slv_req_i;
   logic [NUM_CH-1:0]         slv_val_i;
   logic [NUM_CH-1:0]         a2s_ack_o;
   logic                      f2a_id_req_i;
   logic                      f2a_ack_i;
   logic                      a2f_val_o;
   logic [ID_W-1:0]           a2f_id_o;
   logic [DW-1:0]             a2f_data_o;
   logic [LEN_W-1:0]          a2f_pkglen_sel_o;

   logic [PRIO_W-1:0] prio_a   [NUM_CH];
   logic [LEN_W-1:0]  pkglen_a [NUM_CH];
   logic [DW-1:0]     data_a   [NUM_CH];

   int n_vec = 0;
   int n_err = 0;
   int exp_g [4];

   arb_rr_n #(.NUM_CH(NUM_CH), .DW(DW), .PRIO_W(PRIO_W), .LEN_W(LEN_W)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .slv_prio_i       (slv_prio_i),
      .slv_pkglen_i     (slv_pkglen_i),
      .slv_data_i       (slv_data_i),
      .slv_req_i        (slv_req_i),
      .slv_val_i        (slv_val_i),
      .a2s_ack_o        (a2s_ack_o),
      .f2a_id_req_i     (f2a_id_req_i),
      .f2a_ack_i        (f2a_ack_i),
      .a2f_val_o        (a2f_val_o),
      .a2f_id_o         (a2f_id_o),
      .a2f_data_o       (a2f_data_o),
      .a2f_pkglen_sel_o (a2f_pkglen_sel_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always_comb begin
      slv_prio_i   = '0;
      slv_pkglen_i = '0;
      slv_data_i   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         slv_prio_i[c*PRIO_W +: PRIO_W] = prio_a[c];
         slv_pkglen_i[c*LEN_W +: LEN_W] = pkglen_a[c];
         slv_data_i[c*DW +: DW]         = data_a[c];
      end
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called in IDLE with f2a_id_req_i and the request(s) already driven.
   task automatic grant(input int ch);
      tick;
      chk("ack_in_arb", 64'(a2s_ack_o), 64'd0);
      tick;
      chk("ack_onehot", 64'(a2s_ack_o), 64'(1 << ch));
      chk("grant_id", 64'(a2f_id_o), 64'(ch));
   endtask

   // Drive n consecutive vals on ch; the first nfwd must be forwarded.
   task automatic beats(input int ch, input int n, input int nfwd, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         slv_val_i[ch] = 1'b1;
         data_a[ch]    = base + DW'(i);
         tick;
         if (i == 0) chk("ack_single_pulse", 64'(a2s_ack_o), 64'd0);
         if (i < nfwd) begin
            chk("beat_val", 64'(a2f_val_o), 64'd1);
            chk("beat_data", 64'(a2f_data_o), 64'(base + DW'(i)));
         end else begin
            chk("extra_beat_val", 64'(a2f_val_o), 64'd0);
            chk("extra_beat_hold", 64'(a2f_data_o), 64'(base + DW'(nfwd - 1)));
         end
      end
      slv_val_i[ch] = 1'b0;
      tick;
      chk("idle_val", 64'(a2f_val_o), 64'd0);
      chk("data_hold", 64'(a2f_data_o), 64'(base + DW'(nfwd - 1)));
   endtask

   task automatic finish_pkg;
      f2a_ack_i = 1'b1;
      tick;
      f2a_ack_i = 1'b0;
   endtask

   initial begin
`ifdef ARB_PRIO_EN
      exp_g = '{1, 2, 1, 2};
`else
      exp_g = '{0, 1, 2, 3};
`endif
      rst_i        = 1'b1;
      slv_req_i    = '0;
      slv_val_i    = '0;
      f2a_id_req_i = 1'b0;
      f2a_ack_i    = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         prio_a[c]   = '0;
         pkglen_a[c] = '0;
         data_a[c]   = '0;
      end
      tick;
      tick;
      chk("rst_ack", 64'(a2s_ack_o), 64'd0);
      chk("rst_val", 64'(a2f_val_o), 64'd0);
      chk("rst_id", 64'(a2f_id_o), 64'd0);
      chk("rst_data", 64'(a2f_data_o), 64'd0);
      chk("rst_pkglen", 64'(a2f_pkglen_sel_o), 64'd0);
      rst_i = 1'b0;
      tick;

      // All channels requesting, prio {3,1,1,2}, four packages.
      prio_a[0] = 2'd3; prio_a[1] = 2'd1; prio_a[2] = 2'd1; prio_a[3] = 2'd2;
      slv_req_i    = 4'b1111;
      f2a_id_req_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         grant(exp_g[k]);
         beats(exp_g[k], 4, 4, 32'h1000 + DW'(k * 16));
         finish_pkg;
      end

      // Only ch2 requesting, pkglen 0, data 0xA0..0xA3.
      slv_req_i = 4'b0100;
      for (int c = 0; c < NUM_CH; c++) prio_a[c] = '0;
      grant(2);
      chk("pkglen_ch2", 64'(a2f_pkglen_sel_o), 64'd0);
      beats(2, 4, 4, 32'h0000_00A0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("done_no_ack", 64'(a2s_ack_o), 64'd0);
         chk("done_id_stable", 64'(a2f_id_o), 64'd2);
      end
      finish_pkg;
      chk("id_after_ack", 64'(a2f_id_o), 64'd2);
      grant(2);
      slv_req_i = '0;
      beats(2, 4, 4, 32'h0000_00B0);
      finish_pkg;

      // Formatter not ready: requests present but no arbitration.
      f2a_id_req_i = 1'b0;
      slv_req_i    = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("no_id_req_no_ack", 64'(a2s_ack_o), 64'd0);
      end
      // Requests withdrawn during ARB: back to IDLE, no ack.
      f2a_id_req_i = 1'b1;
      tick;
      slv_req_i = '0;
      tick;
      chk("arb_drop_ack0", 64'(a2s_ack_o), 64'd0);
      tick;
      chk("arb_drop_ack1", 64'(a2s_ack_o), 64'd0);

      // pkglen 5 on ch3, 40 vals: 32 forwarded.
      pkglen_a[3] = 3'd5;
      slv_req_i   = 4'b1000;
      grant(3);
      slv_req_i = '0;
      chk("pkglen_ch3", 64'(a2f_pkglen_sel_o), 64'd5);
      beats(3, 40, 32, 32'h0000_0100);
      finish_pkg;

      // ch0 granted; ch1 val ignored; ch0 prio/pkglen change ignored; early f2a_ack ignored.
      pkglen_a[0] = 3'd1;
      slv_req_i   = 4'b0001;
      grant(0);
      slv_req_i = '0;
      chk("pkglen_ch0", 64'(a2f_pkglen_sel_o), 64'd1);
      slv_val_i[1] = 1'b1;
      data_a[1]    = 32'h0000_0055;
      tick;
      chk("foreign_val", 64'(a2f_val_o), 64'd0);
      slv_val_i[1] = 1'b0;
      pkglen_a[0]  = 3'd3;
      prio_a[0]    = 2'd2;
      f2a_ack_i    = 1'b1;
      tick;
      f2a_ack_i = 1'b0;
      chk("pkglen_stable", 64'(a2f_pkglen_sel_o), 64'd1);
      chk("foreign_val2", 64'(a2f_val_o), 64'd0);
      beats(0, 8, 8, 32'h0000_0200);
      chk("pkglen_stable_end", 64'(a2f_pkglen_sel_o), 64'd1);
      finish_pkg;

      // Reset on beat 5 of 8 on ch1.
      pkglen_a[1] = 3'd1;
      slv_req_i   = 4'b0010;
      grant(1);
      slv_req_i = '0;
      for (int i = 0; i < 5; i++) begin
         slv_val_i[1] = 1'b1;
         data_a[1]    = 32'h0000_0300 + DW'(i);
         tick;
      end
      chk("beat5_val", 64'(a2f_val_o), 64'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async_rst_val", 64'(a2f_val_o), 64'd0);
      chk("async_rst_data", 64'(a2f_data_o), 64'd0);
      chk("async_rst_id", 64'(a2f_id_o), 64'd0);
      chk("async_rst_pkglen", 64'(a2f_pkglen_sel_o), 64'd0);
      chk("async_rst_ack", 64'(a2s_ack_o), 64'd0);
      tick;
      rst_i        = 1'b0;
      slv_val_i[1] = 1'b0;
      tick;
      chk("post_rst_val", 64'(a2f_val_o), 64'd0);
      for (int c = 0; c < NUM_CH; c++) begin
         prio_a[c]   = 2'd1;
         pkglen_a[c] = 3'd0;
      end
      slv_req_i = 4'b1111;
      grant(0);
      slv_req_i = '0;
      beats(0, 4, 4, 32'h0000_0400);
      finish_pkg;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
